cost_accumulator: RTL

- Averages per-sample loss values over a mini-batch of 2**BATCH_LOG2 samples and presents one mean cost per batch.
- Sits directly downstream of the cross-entropy / square-of-errors loss stage.
- Uses a valid/ready handshake on both sides; the result feeds the training monitor and the PS-readable register bank.
- Division is an arithmetic right shift by BATCH_LOG2, with optional round-half-up.

---
 rtl/cost_accumulator_pkg.sv | 15 +
 rtl/cost_mean_shift.sv | 31 +++
 rtl/cost_accumulator.sv | 118 +++++++++++
 3 files changed

// File: rtl/cost_accumulator_pkg.sv
// Shared types for the loss/cost path: sample word, accumulator FSM states and
// the fixed-point scale used by the upstream loss stage.
package cost_accumulator_pkg;

  typedef logic signed [31:0] data_type;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    HOLD   = 2'd2
  } cost_state_t;

  localparam int SIGMOID_DECIMAL_BITS = 12;

endpackage

// File: rtl/cost_mean_shift.sv
// Combinational batch mean: (acc + R) >>> BATCH_LOG2, truncated to data_type.
// COST_ROUND_EN selects R = 2**(BATCH_LOG2-1) (round half up); otherwise R = 0 (floor).
module cost_mean_shift
  import cost_accumulator_pkg::*;
#(
  parameter int BATCH_LOG2 = 3,
  parameter int ACC_W      = 48
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [31:0]      mean
);

  localparam int RND_SH = (BATCH_LOG2 > 0) ? BATCH_LOG2 - 1 : 0;

`ifdef COST_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = (BATCH_LOG2 > 0) ? (ACC_W'(1) << RND_SH) : '0;
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  logic signed [ACC_W-1:0] sum_w;
  logic signed [ACC_W-1:0] shf_w;

  // The sum cannot overflow: ACC_W leaves headroom for 2**BATCH_LOG2 samples plus R.
  always_comb begin
    sum_w = acc + RND;
    shf_w = sum_w >>> BATCH_LOG2;
    mean  = data_type'(shf_w);
  end

endmodule

// File: rtl/cost_accumulator.sv
// Mean of 2**BATCH_LOG2 loss samples; cost_valid 2 edges after last accept (DIVIDE, HOLD).
// loss_ready low in DIVIDE/HOLD; cost held stable until cost_ready. Rounding via COST_ROUND_EN.
module cost_accumulator
  import cost_accumulator_pkg::*;
#(
  parameter int BATCH_LOG2 = 3,
  parameter int ACC_W      = 48,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic signed [31:0] loss_in,
  input  logic              loss_valid,
  output logic              loss_ready,
  output logic signed [31:0] cost,
  output logic              cost_valid,
  input  logic              cost_ready,
  output logic [CNT_W-1:0]  batch_count
);

  if (BATCH_LOG2 < 0 || BATCH_LOG2 > 8) begin : g_bad_batch
    $error("cost_accumulator: BATCH_LOG2 must be in 0..8");
  end
  if (ACC_W < 32 + BATCH_LOG2) begin : g_bad_acc
    $error("cost_accumulator: ACC_W must be >= 32 + BATCH_LOG2");
  end

  localparam logic [BATCH_LOG2:0] CNT_LAST = (BATCH_LOG2 + 1)'((2 ** BATCH_LOG2) - 1);

  cost_state_t             state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [BATCH_LOG2:0]     cnt_q, cnt_d;
  data_type                cost_q, cost_d;
  logic [CNT_W-1:0]        batch_count_q, batch_count_d;
  data_type                mean_w;

  cost_mean_shift #(
    .BATCH_LOG2 (BATCH_LOG2),
    .ACC_W      (ACC_W)
  ) u_mean (
    .acc  (acc_q),
    .mean (mean_w)
  );

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    cost_d        = cost_q;
    batch_count_d = batch_count_q;

    // clear outranks both handshakes in every state.
    unique case (state_q)
      ACCUM: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (loss_valid) begin
          acc_d = acc_q + ACC_W'(loss_in);
          cnt_d = cnt_q + (BATCH_LOG2 + 1)'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (clear) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          cost_d  = mean_w;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (clear) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (cost_ready) begin
          batch_count_d = batch_count_q + CNT_W'(1);
          acc_d         = '0;
          cnt_d         = '0;
          state_d       = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ACCUM;
      acc_q         <= '0;
      cnt_q         <= '0;
      cost_q        <= '0;
      batch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      cost_q        <= cost_d;
      batch_count_q <= batch_count_d;
    end
  end

  assign loss_ready  = (state_q == ACCUM);
  assign cost_valid  = (state_q == HOLD);
  assign cost        = cost_q;
  assign batch_count = batch_count_q;

endmodule
